// File: rtl/rs_entry_array_pkg.sv
// Shared types and widths for the reservation-station entry array.
package rv32i_types;

  localparam int unsigned PHYS_W = 6;
  localparam int unsigned ROB_W  = 5;
  localparam int unsigned OP_W   = 4;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [PHYS_W-1:0] rs1;
    logic              rs1_rdy;
    logic [PHYS_W-1:0] rs2;
    logic              rs2_rdy;
    logic [PHYS_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
  } rs_entry_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [PHYS_W-1:0] rs1;
    logic [PHYS_W-1:0] rs2;
    logic [PHYS_W-1:0] rd;
    logic [ROB_W-1:0]  rob;
  } rs_issue_t;

  // Distance from the ROB head; wraps naturally at ROB_W bits.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] x,
                                               input logic [ROB_W-1:0] head);
    return x - head;
  endfunction

endpackage

// File: rtl/rs_entry_array_free_slot_finder.sv
// Lowest-index free-entry encoder for the reservation station.
module rs_free_slot_finder #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_bits,
  output logic [IDX_W-1:0] idx,
  output logic             any_free
);

  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_bits[i]) begin
        idx      = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_entry_array.sv
// Reservation-station entry storage with CDB wakeup, flush kill and a one-deep issue register.
// Optional macro RS_BYPASS_WAKEUP_EN adds same-cycle CDB wakeup into ready_bits.
module rs_entry_array
  import rv32i_types::*;
#(
  parameter int unsigned RS_DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(RS_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [OP_W-1:0]     disp_op,
  input  logic [PHYS_W-1:0]   disp_rs1,
  input  logic [PHYS_W-1:0]   disp_rs2,
  input  logic                disp_rs1_rdy,
  input  logic                disp_rs2_rdy,
  input  logic [PHYS_W-1:0]   disp_rd,
  input  logic [ROB_W-1:0]    disp_rob,
  input  logic                cdb_valid,
  input  logic [PHYS_W-1:0]   cdb_tag,
  input  logic                flush,
  input  logic [ROB_W-1:0]    flush_rob,
  input  logic [ROB_W-1:0]    rob_head,
  output logic [RS_DEPTH-1:0] ready_bits,
  output logic [RS_DEPTH-1:0] valid_bits,
  output logic                wen,
  output logic [IDX_W-1:0]    insert_idx,
  output logic                issue_slot_free,
  input  logic                sel_grant,
  input  logic [IDX_W-1:0]    sel_idx,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [OP_W-1:0]     iss_op,
  output logic [PHYS_W-1:0]   iss_rs1,
  output logic [PHYS_W-1:0]   iss_rs2,
  output logic [PHYS_W-1:0]   iss_rd,
  output logic [ROB_W-1:0]    iss_rob
);

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  rs_issue_t iss_q, iss_d;

  logic [RS_DEPTH-1:0] occ, kill, match1, match2;
  logic [ROB_W-1:0]    flush_age;
  logic                any_free, grant_ok;

  rs_free_slot_finder #(
    .DEPTH(RS_DEPTH)
  ) u_finder (
    .valid_bits(occ),
    .idx       (insert_idx),
    .any_free  (any_free)
  );

  always_comb begin
    flush_age = rob_age(flush_rob, rob_head);
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      occ[i]        = ent_q[i].valid;
      match1[i]     = cdb_valid && (cdb_tag == ent_q[i].rs1);
      match2[i]     = cdb_valid && (cdb_tag == ent_q[i].rs2);
      kill[i]       = flush && occ[i] && (rob_age(ent_q[i].rob, rob_head) > flush_age);
      valid_bits[i] = occ[i] && !kill[i];
`ifdef RS_BYPASS_WAKEUP_EN
      ready_bits[i] = occ[i] && (ent_q[i].rs1_rdy || match1[i]) && (ent_q[i].rs2_rdy || match2[i]);
`else
      ready_bits[i] = occ[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
`endif
    end
  end

  assign disp_ready      = any_free && !flush;
  assign wen             = disp_valid && disp_ready;
  assign issue_slot_free = !iss_q.valid || iss_ready;
  // A grant on an entry being killed by this flush is dropped.
  assign grant_ok        = sel_grant && !kill[sel_idx];

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (occ[i]) begin
        if (match1[i]) ent_d[i].rs1_rdy = 1'b1;
        if (match2[i]) ent_d[i].rs2_rdy = 1'b1;
      end
      if (kill[i] || (sel_grant && (sel_idx == IDX_W'(i)))) ent_d[i].valid = 1'b0;
      if (wen && (insert_idx == IDX_W'(i))) begin
        ent_d[i].valid   = 1'b1;
        ent_d[i].op      = disp_op;
        ent_d[i].rs1     = disp_rs1;
        ent_d[i].rs1_rdy = disp_rs1_rdy || (cdb_valid && (cdb_tag == disp_rs1));
        ent_d[i].rs2     = disp_rs2;
        ent_d[i].rs2_rdy = disp_rs2_rdy || (cdb_valid && (cdb_tag == disp_rs2));
        ent_d[i].rd      = disp_rd;
        ent_d[i].rob     = disp_rob;
      end
    end

    iss_d = iss_q;
    if (iss_q.valid && iss_ready) iss_d.valid = 1'b0;
    if (flush && iss_q.valid && (rob_age(iss_q.rob, rob_head) > flush_age)) iss_d.valid = 1'b0;
    if (grant_ok) begin
      iss_d.valid = 1'b1;
      iss_d.op    = ent_q[sel_idx].op;
      iss_d.rs1   = ent_q[sel_idx].rs1;
      iss_d.rs2   = ent_q[sel_idx].rs2;
      iss_d.rd    = ent_q[sel_idx].rd;
      iss_d.rob   = ent_q[sel_idx].rob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_q[i] <= '0;
      iss_q <= '0;
    end else begin
      ent_q <= ent_d;
      iss_q <= iss_d;
    end
  end

  assign iss_valid = iss_q.valid;
  assign iss_op    = iss_q.op;
  assign iss_rs1   = iss_q.rs1;
  assign iss_rs2   = iss_q.rs2;
  assign iss_rd    = iss_q.rd;
  assign iss_rob   = iss_q.rob;

  grant_needs_slot: assert property (@(posedge clk) disable iff (rst)
    sel_grant |-> issue_slot_free);
  grant_needs_ready: assert property (@(posedge clk) disable iff (rst)
    sel_grant |-> ready_bits[sel_idx]);

endmodule

// File: doc/rs_entry_array.md
Name: rs_entry_array

Overview:
- Reservation-station entry storage for one functional-unit class.
- Accepts dispatched µops, tracks source-operand readiness from CDB broadcasts, and exports per-entry valid/ready vectors plus an insert index to the downstream age-order selector.
- On the selector's grant, the granted entry moves into a one-deep issue register with a valid/ready handshake to the FU.
- Branch flush kills all entries younger than the mispredicted ROB index.

Parameters:
- RS_DEPTH, 8, number of entries (power of two, ≥2).
- PHYS_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.
- OP_W, 4, opcode field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists and no flush this cycle
- disp_op  in  OP_W  opcode
- disp_rs1, disp_rs2  in  PHYS_W  source tags
- disp_rs1_rdy, disp_rs2_rdy  in  1  source already available
- disp_rd  in  PHYS_W  destination tag
- disp_rob  in  ROB_W  ROB index
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  PHYS_W  broadcast tag
- flush  in  1  branch recovery
- flush_rob  in  ROB_W  mispredicted ROB index (survives)
- rob_head  in  ROB_W  current ROB head, used for age comparison
- ready_bits  out  RS_DEPTH  valid & both sources ready, per entry
- valid_bits  out  RS_DEPTH  entry occupancy (post-kill during flush)
- wen  out  1  disp_valid & disp_ready
- insert_idx  out  log2(RS_DEPTH)  slot written this cycle
- issue_slot_free  out  1  drives selector w_req_right
- sel_grant  in  1  selector w_req_out
- sel_idx  in  log2(RS_DEPTH)  selector queue_raddr
- iss_valid  out  1  issue register valid
- iss_ready  in  1  FU accepts
- iss_op, iss_rs1, iss_rs2, iss_rd, iss_rob  out  issue register fields

Behaviour:
- **Reset:** all entry valid bits = 0; iss_valid = 0; all other outputs derive from these.
  - At reset: disp_ready = 1, ready_bits = 0, valid_bits = 0, insert_idx = 0.
- **Allocation:**
  - insert_idx = lowest-index entry with valid = 0 (registered state only).
  - disp_ready = (any free) & ~flush.
  - On wen, the entry is written at the edge and is valid the next cycle.
- **Wakeup:**
  - For each valid entry, if cdb_valid and cdb_tag equals rsN, set rsN_rdy at the edge.
  - For a dispatch in the same cycle as a matching CDB: the written rdy bit = disp_rsN_rdy | match.
  - Tag 0 is a normal tag; it has no special meaning.
- **ready_bits** = valid & rs1_rdy & rs2_rdy, from registered state (1-cycle wakeup-to-ready).
- **issue_slot_free** = ~iss_valid | iss_ready.
- **Grant:**
  - Sel_grant asserted with issue_slot_free = 0 is an assertion error.
  - When sel_grant is asserted, the entry at sel_idx is copied into the issue register and cleared at the edge, so iss_valid = 1 the next cycle.
  - Sel_grant targeting an invalid or not-ready entry is an assertion error.
- **FU handshake:**
  - iss_valid & iss_ready without a new grant → iss_valid = 0 next cycle.
  - With a new grant → the register is replaced (back-to-back issue, 1 µop/cycle).
  - Issue fields are held stable while iss_valid & ~iss_ready.
- **Flush:**
  - Age of x is defined as (x - rob_head) mod 2^ROB_W.
  - Any entry with age(rob) > age(flush_rob) is killed at the edge.
  - valid_bits shows the surviving mask combinationally in the flush cycle; the selector compacts against it.
  - The issue register is killed under the same rule.
  - A grant in the flush cycle is honoured only if the granted entry survives; otherwise it is dropped and the entry is killed.
  - Dispatch is blocked in the flush cycle.
  - A CDB wakeup in the flush cycle still applies to survivors.
- **Full:** disp_ready = 0. A grant frees its slot at the edge, so dispatch resumes the next cycle.
- **Reset mid-operation:** all state is cleared regardless of flush, grant, or dispatch in that cycle.

Optional Feature:
- Macro: RS_BYPASS_WAKEUP_EN.
- Defined:
  - ready_bits additionally ORs the same-cycle CDB match per source, giving 0-cycle wakeup.
  - A granted entry whose readiness came from the bypass is captured with its rdy bits set.
- Undefined: ready_bits uses registered state only, as described above.

Decomposition:
- Package rv32i_types holds:
  - rs_entry_t struct (valid, op, rs1, rs1_rdy, rs2, rs2_rdy, rd, rob).
  - rs_issue_t struct.
  - Width localparams for PHYS_W, ROB_W, OP_W.
- Sub-module rs_free_slot_finder: parameterised lowest-zero priority encoder producing insert_idx and an any_free flag.

Test Plan:
- Reset, then dispatch op rs1=5 (rdy 0), rs2=7 (rdy 1), rob=3 → valid_bits=0x01, insert_idx=1 next cycle, ready_bits=0x00.
- CDB tag=5 after the above → ready_bits=0x01 one cycle later (same cycle with RS_BYPASS_WAKEUP_EN).
- Grant sel_idx=0 with iss_ready=0 → iss_valid=1, iss_rob=3, valid_bits=0x00, issue_slot_free=0.
  - iss_ready then held low 3 cycles → fields stable.
  - iss_ready=1 → iss_valid=0.
- Fill all 8 entries → disp_ready=0. Grant one in the same cycle as disp_valid → accepted the following cycle at the freed index.
- rob_head=30, entries rob=30,31,0,1, flush_rob=31 → entries with rob 0 and 1 are killed; valid_bits shows the two survivors in the flush cycle.
- Dispatch rs1=9 (rdy 0) concurrent with CDB tag=9 → the entry is written with rs1_rdy=1; ready_bits set next cycle.
